// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the mul_arbiter slice.
// The optional zero-operand bypass is enabled by defining MUL_ARB_ZERO_BYPASS_EN.
package mul_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RELEASE,
    DELIVER
  } state_t;

  // Round-robin pointer advance, wrapping from nreq-1 back to 0.
  function automatic int ptr_inc(input int ptr, input int nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester at or above ptr, wrapping.
// Used by mul_arbiter (optional feature macro: MUL_ARB_ZERO_BYPASS_EN, not used here).
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDXW-1:0] index,
  output logic            any
);

  logic [IDXW-1:0] sel;

  // Scan from the farthest offset down so the closest candidate to ptr wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    sel    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel = IDXW'((int'(ptr) + k) % NREQ);
      if (req[sel]) begin
        onehot      = '0;
        onehot[sel] = 1'b1;
        index       = sel;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters.
// Define MUL_ARB_ZERO_BYPASS_EN to short-circuit transactions with a zero operand.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ack,
  output logic [2*WIDTH-1:0]    rsp_producto,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  output logic                  mul_valid_data,
  input  logic                  mul_ret_ack,
  input  logic                  mul_done,
  output logic                  mul_ack,
  input  logic [2*WIDTH-1:0]    mul_producto
);

  localparam int IDXW = $clog2(NREQ);

  state_t              state, state_n;
  logic [IDXW-1:0]     ptr, ptr_n, owner, owner_n, pick_idx;
  logic [NREQ-1:0]     pick_oh, owner_oh, gnt_n, rsp_valid_n;
  logic                pick_any, bypass, valid_n, ack_n;
  logic [WIDTH-1:0]    win_a, win_b, a_n, b_n;
  logic [2*WIDTH-1:0]  prod_n;

  rr_picker #(
    .NREQ(NREQ),
    .IDXW(IDXW)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .onehot(pick_oh),
    .index (pick_idx),
    .any   (pick_any)
  );

  assign win_a    = req_a[int'(pick_idx)*WIDTH +: WIDTH];
  assign win_b    = req_b[int'(pick_idx)*WIDTH +: WIDTH];
  assign owner_oh = NREQ'(1) << owner;

`ifdef MUL_ARB_ZERO_BYPASS_EN
  assign bypass = (win_a == '0) || (win_b == '0);
`else
  assign bypass = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    owner_n     = owner;
    gnt_n       = '0;
    rsp_valid_n = rsp_valid;
    a_n         = mul_a;
    b_n         = mul_b;
    prod_n      = rsp_producto;
    valid_n     = mul_valid_data;
    ack_n       = mul_ack;
    case (state)
      IDLE: begin
        if (pick_any) begin
          owner_n = pick_idx;
          a_n     = win_a;
          b_n     = win_b;
          gnt_n   = pick_oh;
          if (bypass) begin
            prod_n      = '0;
            rsp_valid_n = pick_oh;
            state_n     = DELIVER;
          end else begin
            valid_n = 1'b1;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mul_ret_ack) begin
          valid_n = 1'b0;
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mul_done) begin
          prod_n  = mul_producto;
          ack_n   = 1'b1;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        // Hold ack until the multiplier has fully dropped its side of both handshakes.
        if (!mul_done && !mul_ret_ack) begin
          ack_n       = 1'b0;
          rsp_valid_n = owner_oh;
          state_n     = DELIVER;
        end
      end
      DELIVER: begin
        if (rsp_ack[owner]) begin
          rsp_valid_n = '0;
          ptr_n       = IDXW'(ptr_inc(int'(owner), NREQ));
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      gnt            <= '0;
      rsp_valid      <= '0;
      rsp_producto   <= '0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_valid_data <= 1'b0;
      mul_ack        <= 1'b0;
    end else begin
      state          <= state_n;
      ptr            <= ptr_n;
      owner          <= owner_n;
      gnt            <= gnt_n;
      rsp_valid      <= rsp_valid_n;
      rsp_producto   <= prod_n;
      mul_a          <= a_n;
      mul_b          <= b_n;
      mul_valid_data <= valid_n;
      mul_ack        <= ack_n;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural multiplier and arbitration model.
// Honours MUL_ARB_ZERO_BYPASS_EN when the RTL is built with it.
module tb_mul_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
`ifdef MUL_ARB_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req, gnt, rsp_valid, rsp_ack;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [2*WIDTH-1:0]    rsp_producto, mul_producto;
  logic [WIDTH-1:0]      mul_a, mul_b;
  logic                  mul_valid_data, mul_ret_ack, mul_done, mul_ack;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  int ref_ptr = 0;
  int checks = 0;
  int failures = 0;
  int lat_lo = 0;
  int lat_hi = 3;
  int rises = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_a         (req_a),
    .req_b         (req_b),
    .gnt           (gnt),
    .rsp_valid     (rsp_valid),
    .rsp_ack       (rsp_ack),
    .rsp_producto  (rsp_producto),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_valid_data(mul_valid_data),
    .mul_ret_ack   (mul_ret_ack),
    .mul_done      (mul_done),
    .mul_ack       (mul_ack),
    .mul_producto  (mul_producto)
  );

  // Behavioural multiplier: ret_ack pulse, random latency, Done_Flag held until ack.
  int m_st, m_cnt;
  logic [WIDTH-1:0] m_a, m_b;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 0; m_cnt <= 0; m_a <= '0; m_b <= '0;
      mul_ret_ack <= 1'b0; mul_done <= 1'b0; mul_producto <= '0;
    end else begin
      case (m_st)
        0: if (mul_valid_data) begin
          mul_ret_ack <= 1'b1; m_a <= mul_a; m_b <= mul_b;
          m_cnt <= int'($urandom_range(lat_hi, lat_lo)); m_st <= 1;
        end
        1: begin
          mul_ret_ack <= 1'b0;
          if (m_cnt == 0) begin
            mul_done <= 1'b1; mul_producto <= 64'(m_a) * 64'(m_b); m_st <= 2;
          end else m_cnt <= m_cnt - 1;
        end
        default: if (mul_ack) begin mul_done <= 1'b0; m_st <= 0; end
      endcase
    end
  end

  logic prev_valid = 1'b0;
  always @(posedge clk) begin
    prev_valid <= mul_valid_data;
    if (mul_valid_data && !prev_valid) rises <= rises + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req[i] = 1'b1;
  endtask

  // Spec rule: first requester at or above the pointer, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic do_reset();
    req = '0; rsp_ack = '0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0; ref_ptr = 0;
  endtask

  task automatic run_txn(input int ack_delay, input bit drop_req, input logic [NREQ-1:0] extra_req,
                         input logic [NREQ-1:0] stray_ack, output int gnt_wait);
    int w, lat, bad;
    bit zero;
    logic [2*WIDTH-1:0] exp_prod;
    w = model_pick(req, ref_ptr);
    exp_prod = 64'(op_a[w]) * 64'(op_b[w]);
    zero = (op_a[w] == 0) || (op_b[w] == 0);
    gnt_wait = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (gnt !== '0) break;
      gnt_wait++;
    end
    checkOutput("gnt", 64'(gnt), 64'(1) << w);
    checkOutput("mul_a", 64'(mul_a), 64'(op_a[w]));
    checkOutput("mul_b", 64'(mul_b), 64'(op_b[w]));
    checkOutput("mul_valid_at_gnt", 64'(mul_valid_data), (BYPASS && zero) ? 64'd0 : 64'd1);
    if (drop_req) req[w] = 1'b0;
    req = req | extra_req;
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      lat++;
      if (n == 0) checkOutput("gnt_pulse", 64'(gnt), 64'd0);
      if (rsp_valid !== '0) break;
    end
    if (BYPASS && zero) checkOutput("bypass_latency", 64'(lat), 64'd1);
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(1) << w);
    checkOutput("rsp_producto", rsp_producto, exp_prod);
    bad = 0;
    rsp_ack = stray_ack & ~(NREQ'(1) << w);
    for (int n = 0; n < ack_delay; n++) begin
      tick();
      if (rsp_valid !== (NREQ'(1) << w) || rsp_producto !== exp_prod || gnt !== '0) bad++;
    end
    if (ack_delay > 0) checkOutput("rsp_hold", 64'(bad), 64'd0);
    rsp_ack = NREQ'(1) << w;
    tick();
    rsp_ack = '0;
    checkOutput("rsp_clear", 64'(rsp_valid), 64'd0);
    ref_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    int gw, base, n;
    req = '0; rsp_ack = '0; req_a = '0; req_b = '0;
    reset = 1'b1;
    tick(); tick();
    checkOutput("reset_gnt", 64'(gnt), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_producto", rsp_producto, 64'd0);
    checkOutput("reset_mul_valid", 64'(mul_valid_data), 64'd0);
    checkOutput("reset_mul_ack", 64'(mul_ack), 64'd0);
    checkOutput("reset_mul_a", 64'(mul_a), 64'd0);
    reset = 1'b0;
    ref_ptr = 0;

    $display("[TB] single request");
    applyStimulus(0, 10, 10);
    run_txn(0, 1'b1, '0, '0, gw);
    checkOutput("gnt_latency", 64'(gw), 64'd0);
    applyStimulus(0, 2, 3);
    applyStimulus(1, 4, 5);
    run_txn(0, 1'b1, '0, '0, gw);
    run_txn(0, 1'b1, '0, '0, gw);

    $display("[TB] all four requesting");
    do_reset();
    applyStimulus(0, 3, 5);
    applyStimulus(1, 7, 9);
    applyStimulus(2, 11, 13);
    applyStimulus(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < NREQ; k++) begin
      run_txn(0, 1'b1, '0, '0, gw);
      if (k > 0) checkOutput("b2b_gnt", 64'(gw), 64'd0);
    end

    $display("[TB] fairness");
    applyStimulus(2, 1, 1);
    run_txn(0, 1'b1, '0, '0, gw);
    applyStimulus(2, 21, 2);
    applyStimulus(3, 8, 8);
    for (int k = 0; k < 4; k++) run_txn(0, 1'b0, '0, '0, gw);
    req = '0;

    $display("[TB] late rsp_ack");
    applyStimulus(1, 123, 456);
    op_a[0] = 99; op_b[0] = 3;
    req_a[0 +: WIDTH] = 99; req_b[0 +: WIDTH] = 3;
    run_txn(20, 1'b1, 4'b0001, 4'b1111, gw);
    run_txn(0, 1'b1, '0, '0, gw);

    $display("[TB] reset during WAIT_DONE");
    lat_lo = 6; lat_hi = 6;
    applyStimulus(2, 6, 7);
    for (n = 0; n < 50; n++) begin tick(); if (gnt !== '0) break; end
    req[2] = 1'b0;
    for (n = 0; n < 20; n++) begin tick(); if (mul_valid_data === 1'b0) break; end
    checkOutput("in_wait_done", 64'(mul_valid_data), 64'd0);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_mul_a", 64'(mul_a), 64'd0);
    checkOutput("async_mul_b", 64'(mul_b), 64'd0);
    checkOutput("async_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("async_mul_ack", 64'(mul_ack), 64'd0);
    tick();
    reset = 1'b0;
    ref_ptr = 0;
    lat_lo = 0; lat_hi = 3;
    applyStimulus(2, 6, 7);
    run_txn(0, 1'b1, '0, '0, gw);

    $display("[TB] zero operand");
    base = rises;
    applyStimulus(0, 19347, 0);
    run_txn(0, 1'b1, '0, '0, gw);
    checkOutput("zero_mul_issues", 64'(rises - base), BYPASS ? 64'd0 : 64'd1);

    $display("[TB] random traffic");
    for (int r = 0; r < 10; r++) begin
      logic [NREQ-1:0] mask;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        if (mask[i])
          applyStimulus(i, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom(), $urandom());
      for (int t = 0; t < NREQ && req != '0; t++)
        run_txn(int'($urandom_range(0, 3)), 1'b1, '0, NREQ'($urandom()), gw);
      req = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
